// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: issue side (in_*) and result side (out_*).
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_hi;
    logic             out_z;
    logic             out_n;
    logic             out_c;
    logic             out_v;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_r, out_hi, out_z, out_n, out_c, out_v
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_r, out_hi, out_z, out_n, out_c, out_v
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with persistent Z/N/C/V flags and carry-chained ops.
// Define ALU_PIPE_MUL_EN to build the WIDTH-cycle shift-add unsigned multiplier for opcode F.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_pipe_if.slave   bus
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [3:0] {
        OP_MOV  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_RLC  = 4'h5,
        OP_RRC  = 4'h6,
        OP_SETC = 4'h7,
        OP_CLRC = 4'h8,
        OP_NOT  = 4'h9,
        OP_NEG  = 4'hA,
        OP_INC  = 4'hB,
        OP_DEC  = 4'hC,
        OP_ADC  = 4'hD,
        OP_SBC  = 4'hE,
        OP_MUL  = 4'hF
    } op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Signed overflow of x+y: equal operand signs, result sign differs.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of x-y: differing operand signs, result sign differs from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    op_e              op_c;
    logic             busy_c;
    logic             accept_c;
    logic [W1-1:0]    a_x_c;
    logic [W1-1:0]    b_x_c;
    logic [W1-1:0]    cin_x_c;
    logic [W1-1:0]    arith_c;
    logic [WIDTH-1:0] alu_r_c;
    flags_t           alu_fl_c;

    logic [WIDTH-1:0] r_q, r_d;
    flags_t           fl_q, fl_d;
    logic             out_valid_q, out_valid_d;

`ifdef ALU_PIPE_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MUL_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W1-1:0]    psum_c;
    logic [W2-1:0]    pstep_c;

    assign busy_c = (state_q == S_MUL_RUN);

    // One shift-add step: upper half accumulates the multiplicand when the current multiplier bit is set.
    assign psum_c  = {1'b0, prod_q[W2-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : W1'(0));
    assign pstep_c = {psum_c, prod_q[WIDTH-1:1]};
`else
    assign busy_c = 1'b0;
`endif

    assign op_c     = op_e'(bus.in_op);
    assign accept_c = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !busy_c && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = r_q;
    assign bus.out_z     = fl_q.z;
    assign bus.out_n     = fl_q.n;
    assign bus.out_c     = fl_q.c;
    assign bus.out_v     = fl_q.v;
`ifdef ALU_PIPE_MUL_EN
    assign bus.out_hi    = hi_q;
`else
    assign bus.out_hi    = '0;
`endif

    // Single-cycle datapath; arithmetic is WIDTH+1 bits so bit WIDTH is carry/borrow.
    always_comb begin
        a_x_c      = {1'b0, bus.in_a};
        b_x_c      = {1'b0, bus.in_b};
        cin_x_c    = W1'(fl_q.c);
        arith_c    = '0;
        alu_r_c    = '0;
        alu_fl_c.c = fl_q.c;
        alu_fl_c.v = 1'b0;
        case (op_c)
            OP_MOV:  alu_r_c = bus.in_b;
            OP_ADD: begin
                arith_c    = a_x_c + b_x_c;
                alu_r_c    = arith_c[WIDTH-1:0];
                alu_fl_c.c = arith_c[WIDTH];
                alu_fl_c.v = add_ovf(bus.in_a, bus.in_b, arith_c[WIDTH-1:0]);
            end
            OP_SUB: begin
                arith_c    = a_x_c - b_x_c;
                alu_r_c    = arith_c[WIDTH-1:0];
                alu_fl_c.c = arith_c[WIDTH];
                alu_fl_c.v = sub_ovf(bus.in_a, bus.in_b, arith_c[WIDTH-1:0]);
            end
            OP_AND:  alu_r_c = bus.in_a & bus.in_b;
            OP_OR:   alu_r_c = bus.in_a | bus.in_b;
            OP_RLC: begin
                alu_r_c    = {bus.in_b[WIDTH-2:0], fl_q.c};
                alu_fl_c.c = bus.in_b[WIDTH-1];
            end
            OP_RRC: begin
                alu_r_c    = {fl_q.c, bus.in_b[WIDTH-1:1]};
                alu_fl_c.c = bus.in_b[0];
            end
            OP_SETC: begin
                alu_r_c    = bus.in_a;
                alu_fl_c.c = 1'b1;
            end
            OP_CLRC: begin
                alu_r_c    = bus.in_a;
                alu_fl_c.c = 1'b0;
            end
            OP_NOT:  alu_r_c = ~bus.in_b;
            OP_NEG: begin
                arith_c    = W1'(0) - b_x_c;
                alu_r_c    = arith_c[WIDTH-1:0];
                alu_fl_c.c = arith_c[WIDTH];
                alu_fl_c.v = sub_ovf(WIDTH'(0), bus.in_b, arith_c[WIDTH-1:0]);
            end
            OP_INC: begin
                arith_c    = b_x_c + W1'(1);
                alu_r_c    = arith_c[WIDTH-1:0];
                alu_fl_c.c = arith_c[WIDTH];
                alu_fl_c.v = add_ovf(bus.in_b, WIDTH'(1), arith_c[WIDTH-1:0]);
            end
            OP_DEC: begin
                arith_c    = b_x_c - W1'(1);
                alu_r_c    = arith_c[WIDTH-1:0];
                alu_fl_c.c = arith_c[WIDTH];
                alu_fl_c.v = sub_ovf(bus.in_b, WIDTH'(1), arith_c[WIDTH-1:0]);
            end
            OP_ADC: begin
                arith_c    = a_x_c + b_x_c + cin_x_c;
                alu_r_c    = arith_c[WIDTH-1:0];
                alu_fl_c.c = arith_c[WIDTH];
                alu_fl_c.v = add_ovf(bus.in_a, bus.in_b, arith_c[WIDTH-1:0]);
            end
            OP_SBC: begin
                arith_c    = a_x_c - b_x_c - cin_x_c;
                alu_r_c    = arith_c[WIDTH-1:0];
                alu_fl_c.c = arith_c[WIDTH];
                alu_fl_c.v = sub_ovf(bus.in_a, bus.in_b, arith_c[WIDTH-1:0]);
            end
            // Without the multiplier this is the whole op; with it, the FSM takes over.
            OP_MUL:  alu_r_c = '0;
        endcase
        alu_fl_c.z = (alu_r_c == '0);
        alu_fl_c.n = alu_r_c[WIDTH-1];
    end

    // Next-state: output hand-off, single-cycle loads and the multiply sequence.
    always_comb begin
        r_d         = r_q;
        fl_d        = fl_q;
        out_valid_d = out_valid_q && !bus.out_ready;
`ifdef ALU_PIPE_MUL_EN
        state_d     = state_q;
        hi_d        = hi_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (op_c == OP_MUL) begin
                        state_d = S_MUL_RUN;
                        mcand_d = bus.in_a;
                        prod_d  = {{WIDTH{1'b0}}, bus.in_b};
                        cnt_d   = '0;
                    end else begin
                        r_d         = alu_r_c;
                        hi_d        = '0;
                        fl_d        = alu_fl_c;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL_RUN: begin
                prod_d = pstep_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_IDLE;
                    r_d         = pstep_c[WIDTH-1:0];
                    hi_d        = pstep_c[W2-1:WIDTH];
                    fl_d.z      = (pstep_c == '0);
                    fl_d.n      = pstep_c[W2-1];
                    fl_d.c      = (pstep_c[W2-1:WIDTH] != '0);
                    fl_d.v      = (pstep_c[W2-1:WIDTH] != '0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`else
        if (accept_c) begin
            r_d         = alu_r_c;
            fl_d        = alu_fl_c;
            out_valid_d = 1'b1;
        end
`endif
    end

    // State registers; reset clears outputs, flags and aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            fl_q        <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= S_IDLE;
            hi_q        <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            r_q         <= r_d;
            fl_q        <= fl_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= state_d;
            hi_q        <= hi_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases then random ops with random back-pressure.
// Expectations for opcode F follow ALU_PIPE_MUL_EN, matching the build of the design.
module tb_alu_pipe;

    localparam int unsigned W = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    typedef struct {
        int         op;
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    bit   rnd_ready;
    logic model_c;
    exp_t sb[$];
    exp_t mon_e;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sgn(input int x);
        return (x > SMAX) ? x - (1 << W) : x;
    endfunction

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic void model(input int op, input int a, input int b, input logic cin,
                                  output exp_t e);
        int     res;
        int     full;
        int     ci;
        longint p;
        ci   = int'(cin);
        res  = 0;
        e.op = op;
        e.hi = '0;
        e.c  = cin;
        e.v  = 1'b0;
        case (op)
            0:  res = b;
            1:  begin full = a + b; res = full & MASK; e.c = (full > MASK);
                      e.v = (sgn(a) + sgn(b) > SMAX) || (sgn(a) + sgn(b) < SMIN); end
            2:  begin full = a - b; res = full & MASK; e.c = (full < 0);
                      e.v = (sgn(a) - sgn(b) > SMAX) || (sgn(a) - sgn(b) < SMIN); end
            3:  res = a & b;
            4:  res = a | b;
            5:  begin res = ((b << 1) | ci) & MASK; e.c = ((b >> (W - 1)) & 1) != 0; end
            6:  begin res = (ci << (W - 1)) | (b >> 1); e.c = (b & 1) != 0; end
            7:  begin res = a; e.c = 1'b1; end
            8:  begin res = a; e.c = 1'b0; end
            9:  res = ~b & MASK;
            10: begin res = (-b) & MASK; e.c = (b != 0); e.v = (-sgn(b) > SMAX); end
            11: begin full = b + 1; res = full & MASK; e.c = (full > MASK); e.v = (sgn(b) + 1 > SMAX); end
            12: begin full = b - 1; res = full & MASK; e.c = (full < 0); e.v = (sgn(b) - 1 < SMIN); end
            13: begin full = a + b + ci; res = full & MASK; e.c = (full > MASK);
                      e.v = (sgn(a) + sgn(b) + ci > SMAX) || (sgn(a) + sgn(b) + ci < SMIN); end
            14: begin full = a - b - ci; res = full & MASK; e.c = (full < 0);
                      e.v = (sgn(a) - sgn(b) - ci > SMAX) || (sgn(a) - sgn(b) - ci < SMIN); end
            default: begin
`ifdef ALU_PIPE_MUL_EN
                p    = longint'(a) * longint'(b);
                e.r  = W'(p & longint'(MASK));
                e.hi = W'((p >> W) & longint'(MASK));
                e.z  = (p == 0);
                e.n  = ((p >> (2 * W - 1)) & 1) != 0;
                e.c  = (e.hi != '0);
                e.v  = (e.hi != '0);
                return;
`else
                res = 0;
`endif
            end
        endcase
        e.r = W'(res);
        e.z = (res == 0);
        e.n = ((res >> (W - 1)) & 1) != 0;
    endfunction

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input int op, input int a, input int b);
        int   waited;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_op    = 4'(op);
        bus.in_a     = W'(a);
        bus.in_b     = W'(b);
        waited       = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            tick();
            waited++;
            if (waited > 100) begin
                vectors++;
                errors++;
                $display("FAIL accept_timeout: op=%0h in_ready=0 for %0d cycles, required 1", op, waited);
                bus.in_valid = 1'b0;
                return;
            end
        end
        model(op, a, b, model_c, e);
        model_c = e.c;
        sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rnd_ready     = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", sb.size(), n);
            sb.delete();
        end
    endtask

    // Monitor: every handed-off result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got r=%h with no result pending", bus.out_r);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_r !== mon_e.r || bus.out_hi !== mon_e.hi || bus.out_z !== mon_e.z ||
                    bus.out_n !== mon_e.n || bus.out_c !== mon_e.c || bus.out_v !== mon_e.v) begin
                    errors++;
                    $display("FAIL result op=%0h: got r=%h hi=%h zncv=%b%b%b%b, want r=%h hi=%h zncv=%b%b%b%b",
                             mon_e.op, bus.out_r, bus.out_hi, bus.out_z, bus.out_n, bus.out_c, bus.out_v,
                             mon_e.r, mon_e.hi, mon_e.z, mon_e.n, mon_e.c, mon_e.v);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;
        int exp_busy;
        vectors       = 0;
        errors        = 0;
        rnd_ready     = 1'b0;
        model_c       = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_r !== '0 || bus.out_hi !== '0 ||
            {bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got valid=%b r=%h hi=%h zncv=%b%b%b%b, want all 0",
                     bus.out_valid, bus.out_r, bus.out_hi, bus.out_z, bus.out_n, bus.out_c, bus.out_v);
        end
        tick();

        // Carry chain and flag corners.
        issue(4'h1, 'h7F, 'h01);
        issue(4'h7, 'h00, 'h00);
        issue(4'hD, 'h10, 'h20);
        issue(4'h1, 'hFF, 'h01);
        issue(4'h2, 'h10, 'h20);
        issue(4'hE, 'h05, 'h01);
        issue(4'h8, 'h00, 'h00);
        issue(4'h5, 'h00, 'h81);
        issue(4'h5, 'h00, 'h00);
        issue(4'h6, 'h00, 'h01);
        issue(4'hA, 'h00, 'h80);
        issue(4'hA, 'h00, 'h00);
        issue(4'hB, 'h00, 'h7F);
        issue(4'hC, 'h00, 'h00);
        issue(4'hC, 'h00, 'h80);
        drain();

        // Multiply latency: in_ready stays low while the iterative loop runs.
`ifdef ALU_PIPE_MUL_EN
        exp_busy = W;
`else
        exp_busy = 0;
`endif
        issue(4'hF, 'hFF, 'hFF);
        busy_cycles = 0;
        while (busy_cycles < 50) begin
            @(negedge clk);
            if (bus.in_ready) break;
            busy_cycles++;
            tick();
        end
        vectors++;
        if (busy_cycles != exp_busy) begin
            errors++;
            $display("FAIL mul_busy: in_ready low for %0d cycles, required %0d", busy_cycles, exp_busy);
        end
        drain();

`ifdef ALU_PIPE_MUL_EN
        // Reset mid-multiply: no result, flags cleared.
        issue(4'hF, 'hFF, 'hFF);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        model_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b0 || {bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== 4'b0000) begin
                errors++;
                $display("FAIL mul_abort cyc%0d: got valid=%b zncv=%b%b%b%b, want valid=0 zncv=0000",
                         i, bus.out_valid, bus.out_z, bus.out_n, bus.out_c, bus.out_v);
            end
            tick();
        end
`endif

        // Stall holds the result; release with a new op in the same cycle.
        bus.out_ready = 1'b0;
        issue(4'h3, 'hF0, 'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_r !== 8'h30) begin
                errors++;
                $display("FAIL stall cyc%0d: got in_ready=%b valid=%b r=%h, want in_ready=0 valid=1 r=30",
                         i, bus.in_ready, bus.out_valid, bus.out_r);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        issue(4'h0, 'h00, 'hAA);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_r !== 8'hAA || bus.out_n !== 1'b1) begin
            errors++;
            $display("FAIL no_bubble: got valid=%b r=%h n=%b, want valid=1 r=aa n=1",
                     bus.out_valid, bus.out_r, bus.out_n);
        end
        tick();
        drain();

        // Random ops under random back-pressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
        end
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
